present_round_ctrl: RTL

PRESENT_ROUND_CTRL -- requirements
Module: present_round_ctrl

---
 rtl/present_pkg.sv | 17 +
 rtl/present_key_addition.sv | 14 +
 rtl/present_key_update.sv | 28 ++
 rtl/present_perm.sv | 20 ++
 rtl/present_sbox.sv | 32 +++
 rtl/present_round_ctrl.sv | 114 +++++++++++
 6 files changed

// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 round controller.
// Holds the controller state encoding, the default round count and the
// data/key/counter widths used by every file of the block.
package present_pkg;

  localparam int KEY_W          = 80;
  localparam int DATA_W         = 64;
  localparam int CNT_W          = 5;
  localparam int ROUNDS_DEFAULT = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/present_key_addition.sv
// PRESENT round-key addition (XOR of state with a 64-bit round key).
// Ports:
//   state_in  - cipher state
//   round_key - 64-bit round key (top bits of the key register)
//   state_out - state XOR round key
module present_key_addition (
  input  logic [63:0] state_in,
  input  logic [63:0] round_key,
  output logic [63:0] state_out
);

  assign state_out = state_in ^ round_key;

endmodule

// File: rtl/present_key_update.sv
// PRESENT-80 key schedule step (combinational).
// Ports:
//   key_in    - current 80-bit key register
//   round_cnt - 5-bit round counter of the round being computed
//   key_out   - key register for the next round
module present_key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [CNT_W-1:0] round_cnt,
  output logic [KEY_W-1:0] key_out
);

  logic [KEY_W-1:0] rotated;
  logic [3:0]       top_sub;

  // Rotate left by 61 is the same as rotate right by 19.
  assign rotated = {key_in[18:0], key_in[79:19]};

  present_sbox u_sbox (
    .in_nib  (rotated[79:76]),
    .out_nib (top_sub)
  );

  assign key_out = {top_sub, rotated[75:20], rotated[19:15] ^ round_cnt,
                    rotated[14:0]};

endmodule

// File: rtl/present_perm.sv
// PRESENT bit permutation: bit i moves to position 16*i mod 63,
// with bit 63 staying in place.
// Ports:
//   in_bits  - 64-bit input
//   out_bits - permuted 64-bit output
module present_perm (
  input  logic [63:0] in_bits,
  output logic [63:0] out_bits
);

  genvar g;
  generate
    for (g = 0; g < 63; g++) begin : g_bit
      assign out_bits[(g * 16) % 63] = in_bits[g];
    end
  endgenerate

  assign out_bits[63] = in_bits[63];

endmodule

// File: rtl/present_sbox.sv
// PRESENT 4-bit substitution box.
// Ports:
//   in_nib  - 4-bit input nibble
//   out_nib - substituted nibble
module present_sbox (
  input  logic [3:0] in_nib,
  output logic [3:0] out_nib
);

  always_comb begin
    out_nib = 4'h0;
    case (in_nib)
      4'h0: out_nib = 4'hC;
      4'h1: out_nib = 4'h5;
      4'h2: out_nib = 4'h6;
      4'h3: out_nib = 4'hB;
      4'h4: out_nib = 4'h9;
      4'h5: out_nib = 4'h0;
      4'h6: out_nib = 4'hA;
      4'h7: out_nib = 4'hD;
      4'h8: out_nib = 4'h3;
      4'h9: out_nib = 4'hE;
      4'hA: out_nib = 4'hF;
      4'hB: out_nib = 4'h8;
      4'hC: out_nib = 4'h4;
      4'hD: out_nib = 4'h7;
      4'hE: out_nib = 4'h1;
      default: out_nib = 4'h2;
    endcase
  end

endmodule

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryption controller, one round per clock.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_valid/in_ready   - job handshake, in_data plaintext, in_key user key
//   out_valid/out_ready - result handshake, out_data ciphertext
//   busy                - high while rounds are being computed
module present_round_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);

  ctrl_state_e       fsm_q, fsm_d;
  logic [DATA_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] added;
  logic [DATA_W-1:0] subbed;
  logic [DATA_W-1:0] permuted;
  logic [KEY_W-1:0]  key_next;

  // Round-key addition also produces the final whitening in DONE.
  present_key_addition u_add (
    .state_in  (state_q),
    .round_key (key_q[79:16]),
    .state_out (added)
  );

  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_sbox
      present_sbox u_sbox (
        .in_nib  (added[4*g +: 4]),
        .out_nib (subbed[4*g +: 4])
      );
    end
  endgenerate

  present_perm u_perm (
    .in_bits  (subbed),
    .out_bits (permuted)
  );

  present_key_update u_key_upd (
    .key_in    (key_q),
    .round_cnt (cnt_q),
    .key_out   (key_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          key_d   = in_key;
          cnt_d   = CNT_W'(1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = permuted;
        key_d   = key_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign busy      = (fsm_q == ST_ROUND);
  assign out_valid = (fsm_q == ST_DONE);
  assign out_data  = (fsm_q == ST_DONE) ? added : '0;

endmodule
